axil_coproc_frontend: RTL and testbench

Parametrised AXI4-Lite slave front end for the crypto coprocessor. It provides a host-visible general register bank, a command FIFO feeding the compute unit through a valid/ready stream, and a result writeback port into the register bank. Unlike the first-generation block, it supports full AXI4-Lite handshakes (independent AW/W acceptance, held B/R responses), byte strobes, SLVERR decode and FIFO backpressure.

---
 rtl/axil_coproc_frontend.sv | 224 ++++++++++++++++++++++
 tb/tb_axil_coproc_frontend.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_coproc_frontend.sv
// AXI4-Lite slave front end for the crypto coprocessor: GPR bank, command FIFO, result writeback.
// Optional feature: define AXIL_FE_IRQ_EN to add the irq output and STATUS[10] irq_pending.
module axil_coproc_frontend #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int CMD_DEPTH = 4
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    input  logic [ADDR_W-1:0]           s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [DATA_W-1:0]           s_axi_wdata,
    input  logic [DATA_W/8-1:0]         s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [ADDR_W-1:0]           s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [DATA_W-1:0]           s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [DATA_W-1:0]           cmd_data,
    input  logic                        res_valid,
    input  logic [$clog2(NUM_REGS)-1:0] res_idx,
    input  logic [DATA_W-1:0]           res_data
`ifdef AXIL_FE_IRQ_EN
    ,
    output logic                        irq
`endif
);

    localparam int IW = ADDR_W - 2;
    localparam int RW = $clog2(NUM_REGS);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = DATA_W / 8;
    localparam logic [IW-1:0] CMD_IDX  = IW'(NUM_REGS);
    localparam logic [IW-1:0] STAT_IDX = IW'(NUM_REGS + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CMD_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Handshakes: a transfer occurs on any edge where valid && ready; once valid is
    // asserted the payload is held stable until that edge; responses hold until accepted.

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] fifo_mem [CMD_DEPTH];
    logic              aw_held, w_held, deferred;
    logic [IW-1:0]     aw_idx;
    logic [DATA_W-1:0] w_data;
    logic [SW-1:0]     w_strb;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              irq_pending;

    logic              fifo_empty, fifo_full, push, pop;
    logic              wr_pending, wr_is_gpr, wr_defer, wr_commit, gpr_we, irq_clr;
    logic [1:0]        wr_resp;
    logic [IW-1:0]     ar_idx;
    logic [DATA_W-1:0] status, rd_word;
    logic [1:0]        rd_resp;
    logic              unused_ok;

    assign s_axi_awready = s_axi_aresetn && !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = s_axi_aresetn && !w_held && !s_axi_bvalid;
    assign s_axi_arready = s_axi_aresetn && !s_axi_rvalid;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign cmd_valid  = !fifo_empty;
    assign cmd_data   = fifo_empty ? '0 : fifo_mem[rd_ptr];
    assign pop        = cmd_valid && cmd_ready;

    // A GPR write colliding with a result writeback waits exactly one cycle, then lands on top.
    assign wr_pending = aw_held && w_held && !s_axi_bvalid;
    assign wr_is_gpr  = (aw_idx < CMD_IDX);
    assign wr_defer   = wr_pending && wr_is_gpr && res_valid && !deferred;
    assign wr_commit  = wr_pending && !wr_defer;
    assign gpr_we     = wr_commit && wr_is_gpr;
    assign push       = wr_commit && (aw_idx == CMD_IDX) && !fifo_full;
    assign irq_clr    = wr_commit && (aw_idx == STAT_IDX) && w_data[10];
    assign wr_resp    = (wr_is_gpr || (aw_idx == STAT_IDX) || ((aw_idx == CMD_IDX) && !fifo_full))
                        ? RESP_OKAY : RESP_SLVERR;

    assign ar_idx    = s_axi_araddr[ADDR_W-1:2];
    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], irq_clr};

    always_comb begin
        status            = '0;
        status[CW-1:0]    = count;
        status[8]         = fifo_empty;
        status[9]         = fifo_full;
        status[10]        = irq_pending;
        rd_word           = '0;
        rd_resp           = RESP_OKAY;
        if (ar_idx < CMD_IDX) begin
            rd_word = regs[ar_idx[RW-1:0]];
        end else if (ar_idx == STAT_IDX) begin
            rd_word = status;
        end else if (ar_idx != CMD_IDX) begin
            rd_resp = RESP_SLVERR;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            deferred     <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi_awaddr[ADDR_W-1:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (wr_defer) begin
                deferred <= 1'b1;
            end
            if (wr_commit) begin
                deferred     <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_resp;
            end
            if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
            end
        end
    end

    // Writeback first, AXI bytes second: the later assignment wins on a deferred collision.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (res_valid) begin
                regs[res_idx] <= res_data;
            end
            if (gpr_we) begin
                for (int b = 0; b < SW; b++) begin
                    if (w_strb[b]) begin
                        regs[aw_idx[RW-1:0]][b*8 +: 8] <= w_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_word;
            s_axi_rresp  <= rd_resp;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= w_data;
        end
    end

`ifdef AXIL_FE_IRQ_EN
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            irq_pending <= 1'b0;
        end else if (res_valid) begin
            irq_pending <= 1'b1;
        end else if (irq_clr) begin
            irq_pending <= 1'b0;
        end
    end
    assign irq = irq_pending;
`else
    assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_axil_coproc_frontend.sv
// Self-checking bench for axil_coproc_frontend: directed scenarios plus randomized traffic
// against a register/queue reference model. Define AXIL_FE_IRQ_EN to exercise the irq path.
`timescale 1ns/1ps
module tb_axil_coproc_frontend;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 16;
    localparam int CMD_DEPTH = 4;

    logic              clk = 1'b0;
    logic              s_axi_aresetn = 1'b0;
    logic [ADDR_W-1:0] s_axi_awaddr = '0;
    logic              s_axi_awvalid = 1'b0;
    logic              s_axi_awready;
    logic [DATA_W-1:0] s_axi_wdata = '0;
    logic [3:0]        s_axi_wstrb = '0;
    logic              s_axi_wvalid = 1'b0;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready = 1'b0;
    logic [ADDR_W-1:0] s_axi_araddr = '0;
    logic              s_axi_arvalid = 1'b0;
    logic              s_axi_arready;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready = 1'b0;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [DATA_W-1:0] cmd_data;
    logic              res_valid = 1'b0;
    logic [3:0]        res_idx = '0;
    logic [DATA_W-1:0] res_data = '0;
`ifdef AXIL_FE_IRQ_EN
    logic              irq;
`endif

    always #5 clk = ~clk;

    axil_coproc_frontend #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .CMD_DEPTH(CMD_DEPTH)
    ) dut (
        .s_axi_aclk(clk),
        .s_axi_aresetn(s_axi_aresetn),
        .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data(cmd_data),
        .res_valid(res_valid),
        .res_idx(res_idx),
        .res_data(res_data)
`ifdef AXIL_FE_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    int n_vectors = 0;
    int n_miscompares = 0;

    logic [31:0] m_regs [NUM_REGS];
    logic [31:0] m_fifo [$];
    bit          m_irq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_fifo.delete();
        m_irq = 1'b0;
    endfunction

    function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx;
        idx = int'(addr[7:2]);
        if (idx < NUM_REGS) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
            return 2'b00;
        end
        if (idx == NUM_REGS) begin
            if (m_fifo.size() == CMD_DEPTH) return 2'b10;
            m_fifo.push_back(data);
            return 2'b00;
        end
        if (idx == NUM_REGS + 1) begin
`ifdef AXIL_FE_IRQ_EN
            if (data[10]) m_irq = 1'b0;
`endif
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic void model_read(input logic [7:0] addr, output logic [31:0] d,
                                       output logic [1:0] r);
        int idx;
        idx = int'(addr[7:2]);
        d = '0;
        r = 2'b00;
        if (idx < NUM_REGS) begin
            d = m_regs[idx];
        end else if (idx == NUM_REGS + 1) begin
            d[7:0] = 8'(m_fifo.size());
            d[8]   = (m_fifo.size() == 0);
            d[9]   = (m_fifo.size() == CMD_DEPTH);
            d[10]  = m_irq;
        end else if (idx != NUM_REGS) begin
            r = 2'b10;
        end
    endfunction

    task automatic do_reset();
        s_axi_aresetn = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0; cmd_ready = 1'b0; res_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_data", cmd_data, 0);
        check("rst_awready", s_axi_awready, 0);
        check("rst_arready", s_axi_arready, 0);
`ifdef AXIL_FE_IRQ_EN
        check("rst_irq", irq, 0);
`endif
        s_axi_aresetn = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        check("idle_awready", s_axi_awready, 1);
        check("idle_wready", s_axi_wready, 1);
    endtask

    // inj drives a result writeback into the cycle in which the write executes.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input bit inj, input logic [3:0] ri, input logic [31:0] rd);
        int cyc, lat, exp_lat, idx;
        bit aw_done, w_done, aw_hs, w_hs;
        logic [1:0] exp_resp;
        idx = int'(addr[7:2]);
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            s_axi_wvalid  = !w_done && (cyc >= w_dly);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(posedge clk);
            #1;
            aw_done |= aw_hs;
            w_done  |= w_hs;
            cyc++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check($sformatf("wr_accept@%0h", addr), {aw_done, w_done}, 2'b11);
        if (inj) begin
            res_valid = 1'b1; res_idx = ri; res_data = rd;
        end
        check("b_early", s_axi_bvalid, 0);
        lat = 0;
        while (!s_axi_bvalid && lat < 20) begin
            @(posedge clk);
            #1;
            res_valid = 1'b0;
            lat++;
        end
        if (inj) m_regs[ri] = rd;
        exp_resp = model_write(addr, data, strb);
`ifdef AXIL_FE_IRQ_EN
        if (inj) m_irq = 1'b1;
`endif
        exp_lat = (inj && idx < NUM_REGS) ? 2 : 1;
        check($sformatf("b_latency@%0h", addr), lat, exp_lat);
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk);
            #1;
            check("b_hold", s_axi_bvalid, 1);
        end
        check($sformatf("bresp@%0h", addr), s_axi_bresp, exp_resp);
        s_axi_bready = 1'b1;
        @(posedge clk);
        #1;
        s_axi_bready = 1'b0;
        check("b_done", s_axi_bvalid, 0);
    endtask

    task automatic axi_read(input logic [7:0] addr, input int r_dly);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit done, hs;
        int cyc;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        done = 0; cyc = 0;
        while (!done && cyc < 20) begin
            hs = s_axi_arready;
            @(posedge clk);
            #1;
            done = hs;
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        check("ar_accept", done, 1);
        model_read(addr, exp_data, exp_resp);
        check("r_valid", s_axi_rvalid, 1);
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk);
            #1;
            check("r_hold", s_axi_rvalid, 1);
        end
        check($sformatf("rdata@%0h", addr), s_axi_rdata, exp_data);
        check($sformatf("rresp@%0h", addr), s_axi_rresp, exp_resp);
        s_axi_rready = 1'b1;
        @(posedge clk);
        #1;
        s_axi_rready = 1'b0;
        check("r_done", s_axi_rvalid, 0);
    endtask

    task automatic pop_one();
        if (m_fifo.size() == 0) begin
            check("cmd_valid_empty", cmd_valid, 0);
        end else begin
            check("cmd_valid", cmd_valid, 1);
            check("cmd_data", cmd_data, m_fifo[0]);
            void'(m_fifo.pop_front());
        end
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
    endtask

    task automatic res_pulse(input logic [3:0] ri, input logic [31:0] rd);
        res_valid = 1'b1; res_idx = ri; res_data = rd;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        m_regs[ri] = rd;
`ifdef AXIL_FE_IRQ_EN
        m_irq = 1'b1;
        check("irq_set", irq, 1);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] addr;
        int r, idx;
        do_reset();

        // Idle reads: GPR3 and STATUS (empty FIFO)
        axi_read(8'h0C, 0);
        axi_read(8'h44, 0);

        // W two cycles before AW, strobed, B held off three cycles
        axi_write(8'h04, 32'hA5A5A5A5, 4'b0101, 2, 0, 3, 0, 4'd0, 32'd0);
        axi_read(8'h04, 1);

        // Fill the command FIFO past capacity, then drain it
        for (int i = 0; i < 5; i++)
            axi_write(8'h40, 32'h11 + 32'(i), 4'hF, 0, 0, 0, 0, 4'd0, 32'd0);
        axi_read(8'h44, 0);
        for (int i = 0; i < 5; i++) pop_one();
        axi_read(8'h44, 0);

        // Writeback collides with an executing GPR2 write
        axi_write(8'h08, 32'h1, 4'hF, 0, 0, 0, 1, 4'd2, 32'hDEADBEEF);
        axi_read(8'h08, 0);

        // Unmapped index 63
        axi_read(8'hFC, 0);
        axi_write(8'hFC, $urandom, 4'hF, 0, 1, 0, 0, 4'd0, 32'd0);
        for (int i = 0; i < NUM_REGS + 2; i++) axi_read(8'(i * 4), 0);

`ifdef AXIL_FE_IRQ_EN
        res_pulse(4'd5, 32'h0BAD_F00D);
        axi_write(8'h44, 32'h400, 4'hF, 0, 0, 0, 0, 4'd0, 32'd0);
        check("irq_clear", irq, 0);
        res_pulse(4'd6, 32'h1234_5678);
        axi_write(8'h44, 32'h400, 4'hF, 0, 0, 0, 1, 4'd7, 32'hCAFE_0001);
        check("irq_set_wins", irq, 1);
        axi_read(8'h44, 0);
        axi_write(8'h44, 32'h400, 4'hF, 1, 0, 0, 0, 4'd0, 32'd0);
        check("irq_clear2", irq, 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      idx = $urandom_range(0, NUM_REGS - 1);
            else if (r < 7) idx = NUM_REGS;
            else if (r < 8) idx = NUM_REGS + 1;
            else            idx = $urandom_range(NUM_REGS + 2, 63);
            addr = {6'(idx), 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 5))
                0, 1: axi_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                                $urandom_range(0, 3), $urandom_range(0, 2), 0, 4'd0, 32'd0);
                2, 3: axi_read(addr, $urandom_range(0, 2));
                4:    res_pulse(4'($urandom_range(0, NUM_REGS - 1)), $urandom);
                default: pop_one();
            endcase
        end

        // Reset while a write is in flight discards it and empties the FIFO
        axi_write(8'h40, 32'h77, 4'hF, 0, 0, 0, 0, 4'd0, 32'd0);
        s_axi_awaddr = 8'h10; s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        do_reset();
        axi_read(8'h10, 0);
        axi_read(8'h44, 0);
        pop_one();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
